servo_pwm_gen: RTL and testbench

Consumes the 21-bit pulse-width word produced by the servo angle decoder (clock cycles at 100 MHz: 100_000 = 1 ms, +555 per degree) and drives the servo control line with a fixed-period PWM frame. Width updates pass through a one-entry shadow register and take effect only at frame boundaries, so pulses are never truncated or glitched. The block sits between the angle decoder and the board pin.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_width_clamp.sv | 26 ++
 rtl/servo_pwm_gen.sv | 144 ++++++++++++++
 tb/tb_servo_pwm_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and types for the servo PWM path.
// Frame/width constants at 100 MHz and the frame FSM state enum.
package servo_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int SERVO_PERIOD_CYCLES = 2_000_000;
  localparam int SERVO_MIN_WIDTH     = 100_000;
  localparam int SERVO_MAX_WIDTH     = 200_000;
  localparam int SERVO_CENTER_WIDTH  = 150_000;
  localparam int SERVO_W             = 21;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } servo_state_t;

endpackage

// File: rtl/servo_width_clamp.sv
// servo_width_clamp: combinational saturating clamp of a pulse width.
// Ports: din (raw width), dout (width limited to [MIN_WIDTH, MAX_WIDTH]).
module servo_width_clamp
  import servo_pkg::*;
#(
  parameter int W         = SERVO_W,
  parameter int MIN_WIDTH = SERVO_MIN_WIDTH,
  parameter int MAX_WIDTH = SERVO_MAX_WIDTH
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [W-1:0] LO = W'(MIN_WIDTH);
  localparam logic [W-1:0] HI = W'(MAX_WIDTH);

  always_comb begin
    dout = din;
    if (din < LO) begin
      dout = LO;
    end else if (din > HI) begin
      dout = HI;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM with a one-entry width shadow.
// Ports: clk, rst_n, enable, width_in/valid/ready, pwm_out, frame_start, running, cur_width.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYCLES = SERVO_PERIOD_CYCLES,
  parameter int MIN_WIDTH     = SERVO_MIN_WIDTH,
  parameter int MAX_WIDTH     = SERVO_MAX_WIDTH,
  parameter int CNT_W         = SERVO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] width_in,
  input  logic             width_valid,
  output logic             width_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             running,
  output logic [CNT_W-1:0] cur_width
);

  if (MIN_WIDTH > MAX_WIDTH || MAX_WIDTH >= PERIOD_CYCLES) begin : g_bad_width
    $error("servo_pwm_gen: need MIN_WIDTH <= MAX_WIDTH < PERIOD_CYCLES");
  end

  if (longint'(PERIOD_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("servo_pwm_gen: CNT_W too narrow for PERIOD_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  servo_state_t     state;
  servo_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] clamped;
  logic [CNT_W-1:0] width_nxt;
  logic             pend_full;
  logic             have_width;
  logic             xfer;
  logic             load;
  logic             pwm_d;
  logic             fs_d;
  logic             run_d;

  servo_width_clamp #(
    .W        (CNT_W),
    .MIN_WIDTH(MIN_WIDTH),
    .MAX_WIDTH(MAX_WIDTH)
  ) u_clamp (
    .din (width_in),
    .dout(clamped)
  );

  assign width_ready = !pend_full;
  assign xfer        = width_valid && width_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable && (have_width || pend_full || xfer)) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (enable) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A load prefers the shadow; an empty shadow lets a same-cycle
  // transfer bypass straight into the frame being started.
  always_comb begin
    width_nxt = cur_width;
    if (load && pend_full) begin
      width_nxt = pend;
    end else if (load && xfer) begin
      width_nxt = clamped;
    end
  end

  always_comb begin
    run_d = (state_nxt == RUN);
    fs_d  = load;
    pwm_d = run_d && (cnt_nxt < width_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_width   <= '0;
      have_width  <= 1'b0;
      pend        <= '0;
      pend_full   <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      cur_width   <= width_nxt;
      pwm_out     <= pwm_d;
      frame_start <= fs_d;
      running     <= run_d;
      if (load && (pend_full || xfer)) begin
        have_width <= 1'b1;
      end
      if (load && pend_full) begin
        pend_full <= 1'b0;
      end else if (xfer && !load) begin
        pend      <= clamped;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed bench with a frame-level reference model.
// Model checked every cycle; per-frame pulse lengths pinned to literals.
module tb_servo_pwm_gen;

  localparam int P = 100;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] width_in;
  logic       width_valid;
  logic       width_ready;
  logic       pwm_out;
  logic       frame_start;
  logic       running;
  logic [7:0] cur_width;

  logic [20:0] cdin;
  logic [20:0] cdout;

  int n_cmp;
  int n_bad;
  int n_print;

  int m_pos;
  int m_cur;
  bit m_have;
  bit m_fs;
  bit m_live;
  int m_pend[$];

  int hi_q[$];
  int fs_cnt;
  int tpos;
  int thi;

  servo_pwm_gen #(
    .PERIOD_CYCLES(P),
    .MIN_WIDTH    (10),
    .MAX_WIDTH    (20),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .width_in   (width_in),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .running    (running),
    .cur_width  (cur_width)
  );

  servo_width_clamp u_clamp_def (
    .din (cdin),
    .dout(cdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  function automatic int mclamp(input int w);
    if (w < 10) return 10;
    if (w > 20) return 20;
    return w;
  endfunction

  // Reference model: frame position, current width, one-slot shadow.
  initial begin
    m_live = 0;
    forever begin
      @(posedge clk);
      begin
        bit xfer;
        bit start;
        int cw;
        xfer  = width_valid && (m_pend.size() == 0);
        cw    = mclamp(int'(width_in));
        start = 0;
        if (!rst_n) begin
          m_pos  = -1;
          m_cur  = 0;
          m_have = 0;
          m_pend.delete();
        end else begin
          if (m_pos < 0) begin
            start = enable && (m_have || m_pend.size() > 0 || xfer);
          end else if (m_pos == P - 1) begin
            if (enable) start = 1;
            else m_pos = -1;
          end else begin
            m_pos++;
          end
          if (start) begin
            m_pos = 0;
            if (m_pend.size() > 0) begin
              m_cur  = m_pend.pop_front();
              m_have = 1;
            end else if (xfer) begin
              m_cur  = cw;
              m_have = 1;
            end
          end else if (xfer) begin
            m_pend.push_back(cw);
          end
        end
        m_fs   = start;
        m_live = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("pwm_out", pwm_out, (m_pos >= 0 && m_pos < m_cur));
        chk("frame_start", frame_start, m_fs);
        chk("running", running, (m_pos >= 0));
        chk("width_ready", width_ready, (m_pend.size() == 0));
        chk("cur_width", cur_width, m_cur);
      end
    end
  end

  // Per-frame high-cycle tally, taken from the DUT pins.
  initial begin
    tpos   = -1;
    thi    = 0;
    fs_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tpos = -1;
      end else begin
        if (frame_start) begin
          tpos = 0;
          thi  = 0;
          fs_cnt++;
        end
        if (running && tpos >= 0) begin
          thi += int'(pwm_out);
          if (tpos == P - 1) begin
            hi_q.push_back(thi);
            tpos = -1;
          end else begin
            tpos++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int w);
    int t;
    t = 0;
    width_valid = 1'b1;
    width_in    = w[7:0];
    while (!width_ready && t < 400) begin
      tick();
      t++;
    end
    chk("send_ready_timeout", width_ready, 1);
    tick();
    width_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!frame_start && t < 300);
    chk("frame_start_timeout", frame_start, 1);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (hi_q.size() < n && t < n * P + 300) begin
      tick();
      t++;
    end
    chk("frame_timeout", (hi_q.size() >= n), 1);
  endtask

  task automatic chk_hi(input string nm, input int exp);
    int act;
    act = -1;
    if (hi_q.size() > 0) act = hi_q.pop_front();
    chk(nm, act, exp);
  endtask

  initial begin
    int fs0;
    n_cmp       = 0;
    n_bad       = 0;
    n_print     = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    width_valid = 1'b0;
    width_in    = '0;
    cdin        = '0;

    cdin = 21'd241_525;
    #1 chk("clamp_dflt_hi", cdout, 200_000);
    cdin = 21'd50_000;
    #1 chk("clamp_dflt_lo", cdout, 100_000);
    cdin = 21'd150_000;
    #1 chk("clamp_dflt_mid", cdout, 150_000);

    tick_n(3);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_running", running, 0);
    chk("rst_ready", width_ready, 1);
    chk("rst_cur", cur_width, 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    tick_n(2);
    chk("idle_no_width", running, 0);

    // 1: first frame after a single width of 15
    send(15);
    chk("s1_fs", frame_start, 1);
    chk("s1_pwm", pwm_out, 1);
    chk("s1_cur", cur_width, 15);
    wait_frames(2);
    chk_hi("s1_hi0", 15);
    chk_hi("s1_hi1", 15);
    tick_n(3);

    // 2: clamp both ends
    send(3);
    wait_frames(2);
    chk_hi("s2_hi_prev", 15);
    chk_hi("s2_hi_low", 10);
    tick_n(3);
    send(250);
    wait_frames(2);
    chk_hi("s2_hi_rep", 10);
    chk_hi("s2_hi_high", 20);
    chk("s2_cur", cur_width, 20);
    tick_n(3);

    // 3: shadow holds 18 while 14 stalls
    send(12);
    wait_fs();
    hi_q.delete();
    chk("s3_cur12", cur_width, 12);
    tick_n(5);
    send(18);
    chk("s3_ready_low", width_ready, 0);
    chk("s3_cur_kept", cur_width, 12);
    send(14);
    chk("s3_cur18", cur_width, 18);
    chk("s3_14_held", width_ready, 0);
    wait_frames(3);
    chk_hi("s3_hi12", 12);
    chk_hi("s3_hi18", 18);
    chk_hi("s3_hi14", 14);
    tick_n(3);

    // 4: bypass on the last frame cycle
    wait_fs();
    hi_q.delete();
    tick_n(P - 1);
    send(16);
    chk("s4_fs", frame_start, 1);
    chk("s4_cur", cur_width, 16);
    chk("s4_ready", width_ready, 1);
    wait_frames(2);
    chk_hi("s4_hi_prev", 14);
    chk_hi("s4_hi16", 16);
    tick_n(3);

    // 5: enable dropped mid-frame
    wait_fs();
    hi_q.delete();
    tick_n(3);
    enable = 1'b0;
    wait_frames(1);
    chk_hi("s5_hi", 16);
    tick_n(3);
    fs0 = fs_cnt;
    chk("s5_running", running, 0);
    tick_n(200);
    chk("s5_no_fs", fs_cnt, fs0);
    chk("s5_pwm", pwm_out, 0);

    // 6: reset mid-pulse with a pending width
    enable = 1'b1;
    wait_fs();
    send(19);
    tick_n(6);
    chk("s6_pwm_hi", pwm_out, 1);
    chk("s6_pend", width_ready, 0);
    rst_n = 1'b0;
    tick();
    chk("s6_pwm", pwm_out, 0);
    chk("s6_running", running, 0);
    chk("s6_ready", width_ready, 1);
    chk("s6_cur", cur_width, 0);
    rst_n = 1'b1;
    fs0 = fs_cnt;
    tick_n(200);
    chk("s6_idle", running, 0);
    chk("s6_no_fs", fs_cnt, fs0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
